addr_decoding_ws: RTL

Parametrised, registered address decoder for the CPU memory bus with per-region wait-state sequencing. It compares the bus address against N inclusive address windows and drives one active-low chip select per window, or the external-memory select when no window matches. It then holds the select for the programmed number of wait states and pulses `ready`. It sits between the CPU address/request path and the internal program/data memories, replacing single-window, zero-wait decoding.

---
 rtl/addr_decoding_ws_if.sv | 24 ++
 rtl/addr_decoding_ws.sv | 102 ++++++++++
 2 files changed

// File: rtl/addr_decoding_ws_if.sv
// CPU-side memory bus between the request path and the address decoder.
// Handshake: req/adress are sampled only when the decoder is IDLE or DONE; ready is a one-cycle completion strobe with no backpressure.
interface addr_decoding_ws_if #(
    parameter int ADDR_W = 32,
    parameter int N_REG  = 2
);
    logic              req;
    logic [ADDR_W-1:0] adress;
    logic [N_REG-1:0]  cs;
    logic              ext_cs;
    logic              ready;
    logic              busy;
    logic [1:0]        dbg_state;

    modport master (
        output req, adress,
        input  cs, ext_cs, ready, busy, dbg_state
    );

    modport slave (
        input  req, adress,
        output cs, ext_cs, ready, busy, dbg_state
    );
endinterface

// File: rtl/addr_decoding_ws.sv
// Registered N-window address decoder with per-window wait-state sequencing.
// Active-low selects are held for the programmed wait states, then ready strobes for one cycle.
module addr_decoding_ws #(
    parameter int                        ADDR_W   = 32,
    parameter int                        N_REG    = 2,
    parameter int                        WAIT_W   = 4,
    parameter logic [N_REG*ADDR_W-1:0]   REG_BASE = {32'h00002000, 32'h00001030},
    parameter logic [N_REG*ADDR_W-1:0]   REG_LAST = {32'h00002FFF, 32'h0000142F},
    parameter logic [N_REG*WAIT_W-1:0]   REG_WAIT = {4'd2, 4'd0},
    parameter logic [WAIT_W-1:0]         EXT_WAIT = 4'd3
) (
    input  logic                 Clk,
    input  logic                 Rst,
    addr_decoding_ws_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [N_REG-1:0]    cs_q, cs_d;
    logic                ext_q, ext_d;

    logic [N_REG-1:0]    cs_dec;
    logic                hit;
    logic [WAIT_W-1:0]   dec_wait;

    // Scan from the highest index down so the lowest matching window overrides.
    always_comb begin : decode
        cs_dec   = '1;
        hit      = 1'b0;
        dec_wait = EXT_WAIT;
        for (int i = N_REG - 1; i >= 0; i--) begin
            if (bus.adress >= REG_BASE[i*ADDR_W +: ADDR_W] &&
                bus.adress <= REG_LAST[i*ADDR_W +: ADDR_W]) begin
                cs_dec   = ~(N_REG'(1) << i);
                hit      = 1'b1;
                dec_wait = REG_WAIT[i*WAIT_W +: WAIT_W];
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin : fsm_reg
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cs_q    <= '1;
            ext_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            ext_q   <= ext_d;
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        cnt_d   = cnt_q;
        cs_d    = cs_q;
        ext_d   = ext_q;
        case (state_q)
            // DONE accepts like IDLE so back-to-back accesses switch selects in one edge.
            S_IDLE, S_DONE: begin
                if (bus.req) begin
                    cs_d    = cs_dec;
                    ext_d   = hit;
                    cnt_d   = dec_wait;
                    state_d = (dec_wait == '0) ? S_DONE : S_WAIT;
                end else begin
                    cs_d    = '1;
                    ext_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - WAIT_W'(1);
                if (cnt_q == WAIT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                cs_d    = '1;
                ext_d   = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.cs        = cs_q;
    assign bus.ext_cs    = ext_q;
    assign bus.ready     = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.dbg_state = state_q;

endmodule
